// File: rtl/lcd_persistence.sv
`default_nettype none
// ============================================================================
// Module      : lcd_persistence
// Description : LCD segment persistence filter. Sweeps segments serially on
//               each tick to update saturating levels and hysteretic states.
//               Publishes the state vector to the renderer on vblank only.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_persistence #(
    parameter int NUM_SEGMENTS  = 576,
    parameter int LEVEL_WIDTH   = 5,
    parameter int RISE_STEP     = 1,
    parameter int FALL_STEP     = 1,
    parameter int ON_THRESHOLD  = 20,
    parameter int OFF_THRESHOLD = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [NUM_SEGMENTS-1:0] raw_segments,
    input  logic                    filter_en,
    input  logic                    vblank_int,
    output logic [NUM_SEGMENTS-1:0] segments_out,
    output logic                    sweep_busy,
    output logic                    overrun
);

    localparam int c_IDX_W = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
    localparam int c_EXT_W = LEVEL_WIDTH + 1;

    localparam logic [LEVEL_WIDTH-1:0] c_LEVEL_MAX  = {LEVEL_WIDTH{1'b1}};
    localparam logic [c_EXT_W-1:0]     c_MAX_EXT    = {1'b0, c_LEVEL_MAX};
    localparam logic [c_EXT_W-1:0]     c_RISE_EXT   = c_EXT_W'(RISE_STEP);
    localparam logic [c_EXT_W-1:0]     c_FALL_EXT   = c_EXT_W'(FALL_STEP);
    localparam logic [c_EXT_W-1:0]     c_ON_EXT     = c_EXT_W'(ON_THRESHOLD);
    localparam logic [c_EXT_W-1:0]     c_OFF_EXT    = c_EXT_W'(OFF_THRESHOLD);
    localparam logic [c_IDX_W-1:0]     c_LAST_IDX   = c_IDX_W'(NUM_SEGMENTS - 1);
    localparam logic [c_IDX_W-1:0]     c_IDX_ONE    = c_IDX_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                    r_fsm;
    state_t                    w_fsm_next;

    logic                      r_prev_tick;
    logic                      r_prev_vblank;
    logic                      r_pending;
    logic                      r_overrun;
    logic [NUM_SEGMENTS-1:0]   r_snapshot;
    logic [NUM_SEGMENTS-1:0]   r_state;
    logic [NUM_SEGMENTS-1:0]   r_segments_out;
    logic [c_IDX_W-1:0]        r_index;
    logic [LEVEL_WIDTH-1:0]    r_level [NUM_SEGMENTS];

    logic                      w_tick_edge;
    logic                      w_vblank_edge;
    logic                      w_in_sweep;
    logic                      w_sweep_start;
    logic                      w_sweep_last;
    logic                      w_publish;

    logic                      w_raw_bit;
    logic                      w_old_state;
    logic [LEVEL_WIDTH-1:0]    w_old_level;
    logic [c_EXT_W-1:0]        w_old_ext;
    logic [c_EXT_W-1:0]        w_rise_sum;
    logic [LEVEL_WIDTH-1:0]    w_level_up;
    logic [LEVEL_WIDTH-1:0]    w_level_down;
    logic [LEVEL_WIDTH-1:0]    w_new_level;
    logic [c_EXT_W-1:0]        w_new_ext;
    logic                      w_new_state;

    assign w_tick_edge   = tick & ~r_prev_tick;
    assign w_vblank_edge = vblank_int & ~r_prev_vblank;
    assign w_in_sweep    = (r_fsm == ST_SWEEP);
    assign w_sweep_start = (r_fsm == ST_IDLE) & w_tick_edge;
    assign w_sweep_last  = w_in_sweep & (r_index == c_LAST_IDX);
    // Publishing only from IDLE guarantees the whole vector belongs to one sweep.
    assign w_publish     = (r_fsm == ST_IDLE) & (w_vblank_edge | r_pending);

    assign w_raw_bit   = r_snapshot[r_index];
    assign w_old_state = r_state[r_index];
    assign w_old_level = r_level[r_index];
    assign w_old_ext   = {1'b0, w_old_level};

    // Saturating arithmetic is done one bit wider so the level never wraps.
    always_comb begin
        w_rise_sum   = w_old_ext + c_RISE_EXT;
        w_level_up   = (w_rise_sum > c_MAX_EXT) ? c_LEVEL_MAX : w_rise_sum[LEVEL_WIDTH-1:0];
        w_level_down = (w_old_ext >= c_FALL_EXT)
                     ? w_old_level - c_FALL_EXT[LEVEL_WIDTH-1:0]
                     : '0;
        w_new_level  = w_old_level;
        w_new_state  = w_old_state;
        w_new_ext    = '0;
        if (filter_en) begin
            w_new_level = w_raw_bit ? w_level_up : w_level_down;
            w_new_ext   = {1'b0, w_new_level};
            if (!w_old_state && (w_new_ext >= c_ON_EXT)) begin
                w_new_state = 1'b1;
            end else if (w_old_state && (w_new_ext <= c_OFF_EXT)) begin
                w_new_state = 1'b0;
            end
        end else begin
            // Bypass parks the level at a rail so re-enabling is glitch-free.
            w_new_level = w_raw_bit ? c_LEVEL_MAX : '0;
            w_new_state = w_raw_bit;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE:  if (w_tick_edge)  w_fsm_next = ST_SWEEP;
            ST_SWEEP: if (w_sweep_last) w_fsm_next = ST_IDLE;
            default:                    w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_tick   <= 1'b0;
            r_prev_vblank <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_prev_tick   <= tick;
            r_prev_vblank <= vblank_int;
            r_overrun     <= w_in_sweep & w_tick_edge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snapshot <= '0;
            r_index    <= '0;
        end else if (w_sweep_start) begin
            r_snapshot <= raw_segments;
            r_index    <= '0;
        end else if (w_in_sweep) begin
            r_index    <= w_sweep_last ? '0 : r_index + c_IDX_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                r_level[i] <= '0;
            end
        end else if (w_in_sweep) begin
            r_state[r_index] <= w_new_state;
            r_level[r_index] <= w_new_level;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending      <= 1'b0;
            r_segments_out <= '0;
        end else if (w_publish) begin
            r_pending      <= 1'b0;
            r_segments_out <= r_state;
        end else if (w_in_sweep && w_vblank_edge) begin
            r_pending      <= 1'b1;
        end
    end

    assign segments_out = r_segments_out;
    assign sweep_busy   = w_in_sweep;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_persistence.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_persistence
// Description : Directed self-checking bench for lcd_persistence (8 segments).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_persistence;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         tick;
    logic [N-1:0] raw_segments;
    logic         filter_en;
    logic         vblank_int;
    logic [N-1:0] segments_out;
    logic         sweep_busy;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    lcd_persistence #(
        .NUM_SEGMENTS  (N),
        .LEVEL_WIDTH   (5),
        .RISE_STEP     (1),
        .FALL_STEP     (1),
        .ON_THRESHOLD  (20),
        .OFF_THRESHOLD (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .raw_segments (raw_segments),
        .filter_en    (filter_en),
        .vblank_int   (vblank_int),
        .segments_out (segments_out),
        .sweep_busy   (sweep_busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep: the sweep must last exactly N cycles after the start edge.
    task automatic do_tick(input logic [N-1:0] raw);
        int n;
        raw_segments = raw;
        tick = 1'b1;
        step();
        tick = 1'b0;
        n = 0;
        while (sweep_busy && n < 40) begin
            step();
            n++;
        end
        check("sweep_len", n, N);
    endtask

    task automatic do_vblank();
        vblank_int = 1'b1;
        step();
        vblank_int = 1'b0;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        tick         = 1'b0;
        raw_segments = '0;
        filter_en    = 1'b1;
        vblank_int   = 1'b0;
        step(); step(); step();
        check("reset_seg", segments_out, 8'h00);
        check("reset_busy", sweep_busy, 1'b0);
        check("reset_ovr", overrun, 1'b0);
        reset = 1'b0;
        step();

        // Alternating raw: level toggles 1/0, state never sets
        for (int i = 0; i < 100; i++) begin
            do_tick((i % 2 == 0) ? 8'h01 : 8'h00);
        end
        do_vblank();
        check("alt_no_set", segments_out, 8'h00);

        // Rise: 19 ticks -> level 19, still off; tick 20 -> on
        for (int i = 0; i < 19; i++) do_tick(8'h01);
        do_vblank();
        check("rise_19", segments_out, 8'h00);
        do_tick(8'h01);
        do_vblank();
        check("rise_20", segments_out, 8'h01);

        // Saturate to 40 ticks: a wrapping level would have cleared the state
        for (int i = 0; i < 20; i++) do_tick(8'h01);
        do_vblank();
        check("sat_40", segments_out, 8'h01);

        // Fall from 31: level 13 after 18 ticks keeps it on, 12 clears it
        for (int i = 0; i < 18; i++) do_tick(8'h00);
        do_vblank();
        check("fall_18", segments_out, 8'h01);
        do_tick(8'h00);
        do_vblank();
        check("fall_19", segments_out, 8'h00);

        // Bypass: state follows raw directly
        filter_en = 1'b0;
        do_tick(8'hA5);
        do_vblank();
        check("bypass_a5", segments_out, 8'hA5);

        // Overrun at 3 cycles in, vblank at 2 cycles in (bypass, raw 5A)
        raw_segments = 8'h5A;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("ovr_busy_start", sweep_busy, 1'b1);
        step();
        vblank_int = 1'b1;
        step();
        vblank_int = 1'b0;
        tick = 1'b1;
        raw_segments = 8'hFF;
        check("ovr_before", overrun, 1'b0);
        step();
        tick = 1'b0;
        check("ovr_pulse", overrun, 1'b1);
        step();
        check("ovr_after", overrun, 1'b0);
        step(); step(); step();
        check("busy_cycle8", sweep_busy, 1'b1);
        check("no_midsweep_pub", segments_out, 8'hA5);
        step();
        check("busy_fall", sweep_busy, 1'b0);
        check("pub_not_yet", segments_out, 8'hA5);
        step();
        check("pending_pub", segments_out, 8'h5A);
        check("no_restart", sweep_busy, 1'b0);
        step();
        check("no_restart2", sweep_busy, 1'b0);

        // Re-enable filter from saturated levels: clears after 19 ticks
        filter_en = 1'b1;
        for (int i = 0; i < 18; i++) do_tick(8'h00);
        do_vblank();
        check("reen_18", segments_out, 8'h5A);
        do_tick(8'h00);
        do_vblank();
        check("reen_19", segments_out, 8'h00);

        // Reset mid-sweep: outputs clear immediately, levels restart at 0
        filter_en = 1'b0;
        do_tick(8'hFF);
        do_vblank();
        check("pre_reset_ff", segments_out, 8'hFF);
        filter_en = 1'b1;
        raw_segments = 8'hFF;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1;
        #1;
        check("rst_seg", segments_out, 8'h00);
        check("rst_busy", sweep_busy, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 19; i++) do_tick(8'hFF);
        do_vblank();
        check("post_rst_19", segments_out, 8'h00);
        do_tick(8'hFF);
        do_vblank();
        check("post_rst_20", segments_out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_persistence.md
Name: lcd_persistence

Overview:
Parametrised LCD segment persistence filter between the segment normaliser and the mask/segment renderer. It integrates each raw segment bit into a saturating level on every 1 kHz tick, and derives a displayed state with separate on/off thresholds (hysteresis) and independent rise/fall rates. Segments are swept serially, one per clock, to keep the per-segment level store in RAM-friendly form. Results are published to the renderer only on vblank, never mid-frame and never mid-sweep.

Parameters:
NUM_SEGMENTS, 576, number of segment bits (flattened x*y*z), >=2
LEVEL_WIDTH, 5, bits per persistence level; LEVEL_MAX = 2^LEVEL_WIDTH-1
RISE_STEP, 1, level increment per tick while raw=1, 1..LEVEL_MAX
FALL_STEP, 1, level decrement per tick while raw=0, 1..LEVEL_MAX
ON_THRESHOLD, 20, state turns on when updated level >= this
OFF_THRESHOLD, 12, state turns off when updated level <= this; OFF_THRESHOLD < ON_THRESHOLD <= LEVEL_MAX

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  1 kHz divider level; rising edge starts a sweep
raw_segments  in  NUM_SEGMENTS  normalised raw segment bits
filter_en  in  1  1 = persistence filter; 0 = bypass (state follows raw)
vblank_int  in  1  vblank level; rising edge requests publish
segments_out  out  NUM_SEGMENTS  published filtered segments for renderer
sweep_busy  out  1  high while the sweep FSM is in SWEEP
overrun  out  1  one-cycle pulse: tick edge arrived while SWEEP

Behaviour:
- Reset (async assert): all levels 0, all states 0, segments_out 0, snapshot 0, index 0, prev_tick/prev_vblank 0, pending 0, FSM IDLE, sweep_busy 0, overrun 0. Reset mid-sweep aborts the sweep; no partial publish.
- Edge detect: tick_edge = tick & ~prev_tick; vblank_edge = vblank_int & ~prev_vblank. Both prev registers update every clock.
- FSM IDLE: on tick_edge, capture raw_segments into the snapshot, index <= 0, go to SWEEP. sweep_busy is high from the next cycle.
- FSM SWEEP: each cycle processes segment[index] using snapshot bit r, old level L and old state S.
  - Filter mode: if r, L' = min(L+RISE_STEP, LEVEL_MAX); else L' = max(L-FALL_STEP, 0). Compute in LEVEL_WIDTH+1 bits; no wrap.
  - State update: if S=0 and L'>=ON_THRESHOLD, S'=1. If S=1 and L'<=OFF_THRESHOLD, S'=0. Otherwise S'=S.
  - Bypass mode (filter_en=0): S'=r; L'=LEVEL_MAX if r else 0. Re-enabling the filter therefore starts from a saturated level, with no visible glitch.
  - index increments. On index = NUM_SEGMENTS-1, the segment is processed and the FSM returns to IDLE. A sweep takes exactly NUM_SEGMENTS cycles.
- tick_edge while in SWEEP (including the final cycle): ignored, with no restart and no snapshot change. overrun pulses for 1 cycle.
- Publish: segments_out <= state vector, in a cycle where FSM=IDLE and (vblank_edge or pending); pending is cleared in that cycle.
  - vblank_edge during SWEEP (including the final cycle) sets pending instead. The publish then occurs in the first IDLE cycle and includes the final segment.
  - Publishing from IDLE uses the full vector, which is always coherent. segments_out is visible 1 cycle after the publishing edge.
- tick_edge and a publish in the same IDLE cycle: the publish uses the pre-sweep states, and the sweep starts normally.
- Multiple vblank edges during one sweep: a single publish.
- raw_segments may change freely during SWEEP; only the snapshot is used.

Test Plan:
1. NUM_SEGMENTS=8, defaults, bit0 raw=1: state0 turns on at the 20th tick (level 20). A vblank edge after that sweep gives segments_out=8'h01; after the 19th tick it still gives 8'h00.
2. Saturate bit0 (40 ticks, level 31), then raw=0: state stays 1 through tick 18 (level 13) and clears at tick 19 (level 12). The published bit follows on the next vblank.
3. Bit0 raw alternating 1/0 on each tick from level 0, for 100 ticks: level oscillates 0/1, state never sets, segments_out stays 0. Overflow check: 40 rise ticks give level 31, never 0.
4. Tick edge 3 cycles into a sweep: overrun is high for exactly 1 cycle, sweep_busy stays high 8 cycles total, and no second sweep starts. A vblank edge 2 cycles into a sweep: segments_out changes exactly 1 cycle after sweep_busy falls.
5. filter_en=0, raw=8'hA5, one tick + vblank: segments_out=8'hA5. Then filter_en=1, raw=0: the state clears after 19 ticks.
6. Assert reset 4 cycles into a sweep: all outputs are 0 immediately. After release, the next tick restarts from index 0 with levels 0.
